// File: rtl/perf_pkg.sv
// Shared constants for the performance-counter register port and its arbiter.
package perf_pkg;

    localparam int PERF_ADDR_W  = 4;
    localparam int PERF_WDATA_W = 3;

    localparam logic [PERF_ADDR_W-1:0] PERF_ADDR_CTRL = 4'd0;
    localparam logic [PERF_ADDR_W-1:0] PERF_ADDR_HI   = 4'd0;
    localparam logic [PERF_ADDR_W-1:0] PERF_ADDR_LO   = 4'd4;

    localparam logic [1:0] PERF_CTRL_CLEAR = 2'd0;
    localparam logic [1:0] PERF_CTRL_RUN   = 2'd1;
    localparam logic [1:0] PERF_CTRL_HOLD  = 2'd2;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the pointer, with wrap.
module perf_rr_arbiter
    import perf_pkg::*;
#(
    parameter int NCORES = 4,
    localparam int ID_W  = id_width(NCORES)
) (
    input  logic [NCORES-1:0] req_i,
    input  logic [ID_W-1:0]   ptr_i,
    output logic [NCORES-1:0] gnt_o,
    output logic [ID_W-1:0]   idx_o,
    output logic              any_o
);

    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NCORES) j = j - NCORES;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/perf_mmio_arbiter.sv
// Round-robin sharing of the perf counter register port among NCORES cores,
// two-stage pipeline returning the counter's read data two cycles after acceptance.
module perf_mmio_arbiter
    import perf_pkg::*;
#(
    parameter int NCORES = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NCORES-1:0]              req_valid_i,
    input  logic [NCORES-1:0]              req_we_i,
    input  logic [PERF_ADDR_W*NCORES-1:0]  req_addr_i,
    input  logic [PERF_WDATA_W*NCORES-1:0] req_wdata_i,
    output logic [NCORES-1:0]              req_ready_o,
    output logic [NCORES-1:0]              resp_valid_o,
    output logic [31:0]                    resp_rdata_o,
    output logic [PERF_ADDR_W-1:0]         cntr_addr_o,
    output logic [PERF_WDATA_W-1:0]        cntr_wdata_o,
    output logic                           cntr_w_en_o,
    input  logic [31:0]                    cntr_rdata_i
);

    localparam int ID_W = id_width(NCORES);

    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [NCORES-1:0]       gnt;
    logic [ID_W-1:0]         win_idx;
    logic                    any_gnt, accept;
    logic                    sel_we;
    logic [PERF_ADDR_W-1:0]  sel_addr;
    logic [PERF_WDATA_W-1:0] sel_wdata;

    logic                    s1_vld_q, s1_we_q, s2_vld_q, s2_we_q;
    logic [ID_W-1:0]         s1_id_q, s2_id_q;
    logic [PERF_ADDR_W-1:0]  addr_q;
    logic [PERF_WDATA_W-1:0] wdata_q;
    logic [31:0]             rdata_q;

    perf_rr_arbiter #(.NCORES(NCORES)) u_rr (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (win_idx),
        .any_o (any_gnt)
    );

    assign req_ready_o = rst_i ? '0 : gnt;
    assign accept      = any_gnt & ~rst_i;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (win_idx == ID_W'(k)) begin
                sel_we    = req_we_i[k];
                sel_addr  = req_addr_i[PERF_ADDR_W*k +: PERF_ADDR_W];
                sel_wdata = req_wdata_i[PERF_WDATA_W*k +: PERF_WDATA_W];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) ptr_d = (win_idx == ID_W'(NCORES-1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_we_q  <= 1'b0;
            s1_id_q  <= '0;
            s2_vld_q <= 1'b0;
            s2_we_q  <= 1'b0;
            s2_id_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            // stage 1: drive the counter port
            s1_vld_q <= accept;
            s1_we_q  <= accept & sel_we;
            s1_id_q  <= win_idx;
            if (accept) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            // stage 2: counter read data is now valid
            s2_vld_q <= s1_vld_q;
            s2_we_q  <= s1_we_q;
            s2_id_q  <= s1_id_q;
            rdata_q  <= resp_rdata_o;
        end
    end

    assign cntr_addr_o  = addr_q;
    assign cntr_wdata_o = wdata_q;
    // Suppress a pending write pulse in the cycle reset is asserted.
    assign cntr_w_en_o  = s1_we_q & ~rst_i;

    always_comb begin
        resp_valid_o = '0;
        for (int k = 0; k < NCORES; k++) begin
            resp_valid_o[k] = s2_vld_q && (s2_id_q == ID_W'(k));
        end
    end

    assign resp_rdata_o = s2_vld_q ? (s2_we_q ? 32'd0 : cntr_rdata_i) : rdata_q;

endmodule

// File: tb/tb_perf_mmio_arbiter.sv
// Directed table-driven bench for perf_mmio_arbiter (NCORES=4) plus a short NCORES=1 sequence.
module tb_perf_mmio_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid, req_we, req_ready, resp_valid;
    logic [15:0] req_addr;
    logic [11:0] req_wdata;
    logic [31:0] resp_rdata, cntr_rdata;
    logic [3:0]  cntr_addr;
    logic [2:0]  cntr_wdata;
    logic        cntr_w_en;

    logic        v1, we1, rdy1, rv1, wen1;
    logic [3:0]  a1, ca1;
    logic [2:0]  wd1, cwd1;
    logic [31:0] rd1, rr1;

    int n_chk  = 0;
    int n_fail = 0;

    perf_mmio_arbiter #(.NCORES(4)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_ready_o  (req_ready),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .cntr_addr_o  (cntr_addr),
        .cntr_wdata_o (cntr_wdata),
        .cntr_w_en_o  (cntr_w_en),
        .cntr_rdata_i (cntr_rdata)
    );

    perf_mmio_arbiter #(.NCORES(1)) u_dut1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (v1),
        .req_we_i     (we1),
        .req_addr_i   (a1),
        .req_wdata_i  (wd1),
        .req_ready_o  (rdy1),
        .resp_valid_o (rv1),
        .resp_rdata_o (rr1),
        .cntr_addr_o  (ca1),
        .cntr_wdata_o (cwd1),
        .cntr_w_en_o  (wen1),
        .cntr_rdata_i (rd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  we;
        logic [15:0] addr;
        logic [11:0] wd;
        logic [31:0] rd;
        logic [3:0]  rdy;
        logic [3:0]  caddr;
        logic [2:0]  cwd;
        logic        wen;
        logic [3:0]  rv;
        logic [31:0] rr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [3:0] v, input logic [3:0] we,
                                input logic [15:0] addr, input logic [11:0] wd,
                                input logic [31:0] rd, input logic [3:0] rdy,
                                input logic [3:0] caddr, input logic [2:0] cwd,
                                input logic wen, input logic [3:0] rv, input logic [31:0] rr);
        vec_t t;
        t.rst = r; t.v = v; t.we = we; t.addr = addr; t.wd = wd; t.rd = rd;
        t.rdy = rdy; t.caddr = caddr; t.cwd = cwd; t.wen = wen; t.rv = rv; t.rr = rr;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; cntr_rdata = '0;
        v1 = 1'b0; we1 = 1'b0; a1 = '0; wd1 = '0; rd1 = '0;

        //  rst v    we   addr      wd       rd        rdy  ca cwd wen rv   rr
        add(1, 4'hF, 4'h0, 16'h0000, 12'h000, 32'h000, 4'h0, 0, 0, 0, 4'h0, 32'h000);
        add(0, 4'h1, 4'h0, 16'h0004, 12'h000, 32'h000, 4'h1, 0, 0, 0, 4'h0, 32'h000);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h000, 4'h0, 4, 0, 0, 4'h0, 32'h000);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h123, 4'h0, 4, 0, 0, 4'h1, 32'h123);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h555, 4'h0, 4, 0, 0, 4'h0, 32'h123);
        add(0, 4'h4, 4'h4, 16'h0000, 12'h040, 32'h000, 4'h4, 4, 0, 0, 4'h0, 32'h123);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h777, 4'h0, 0, 1, 1, 4'h0, 32'h123);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h777, 4'h0, 0, 1, 0, 4'h4, 32'h000);
        add(0, 4'h8, 4'h0, 16'h4000, 12'h000, 32'h000, 4'h8, 0, 1, 0, 4'h0, 32'h000);
        add(0, 4'hF, 4'h0, 16'h4040, 12'h000, 32'h000, 4'h1, 4, 0, 0, 4'h0, 32'h000);
        add(0, 4'hE, 4'h0, 16'h4040, 12'h000, 32'hAAA, 4'h2, 0, 0, 0, 4'h8, 32'hAAA);
        add(0, 4'hC, 4'h0, 16'h4040, 12'h000, 32'h0B0, 4'h4, 4, 0, 0, 4'h1, 32'h0B0);
        add(0, 4'h8, 4'h0, 16'h4040, 12'h000, 32'h0B1, 4'h8, 0, 0, 0, 4'h2, 32'h0B1);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h0B2, 4'h0, 4, 0, 0, 4'h4, 32'h0B2);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h0B3, 4'h0, 4, 0, 0, 4'h8, 32'h0B3);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h000, 4'h0, 4, 0, 0, 4'h0, 32'h0B3);
        add(0, 4'hA, 4'h0, 16'h0040, 12'h000, 32'h000, 4'h2, 4, 0, 0, 4'h0, 32'h0B3);
        add(0, 4'hA, 4'h0, 16'h0040, 12'h000, 32'h000, 4'h8, 4, 0, 0, 4'h0, 32'h0B3);
        add(0, 4'hA, 4'h0, 16'h0040, 12'h000, 32'h0C0, 4'h2, 0, 0, 0, 4'h2, 32'h0C0);
        add(0, 4'hA, 4'h0, 16'h0040, 12'h000, 32'h0C1, 4'h8, 4, 0, 0, 4'h8, 32'h0C1);
        add(0, 4'hA, 4'h0, 16'h0040, 12'h000, 32'h0C2, 4'h2, 0, 0, 0, 4'h2, 32'h0C2);
        add(0, 4'hA, 4'h0, 16'h0040, 12'h000, 32'h0C3, 4'h8, 4, 0, 0, 4'h8, 32'h0C3);
        add(0, 4'hA, 4'h0, 16'h0040, 12'h000, 32'h0C4, 4'h2, 0, 0, 0, 4'h2, 32'h0C4);
        add(0, 4'hA, 4'h0, 16'h0040, 12'h000, 32'h0C5, 4'h8, 4, 0, 0, 4'h8, 32'h0C5);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h0C6, 4'h0, 0, 0, 0, 4'h2, 32'h0C6);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h0C7, 4'h0, 0, 0, 0, 4'h8, 32'h0C7);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h000, 4'h0, 0, 0, 0, 4'h0, 32'h0C7);
        add(0, 4'h2, 4'h2, 16'h0000, 12'h010, 32'h000, 4'h2, 0, 0, 0, 4'h0, 32'h0C7);
        add(1, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h000, 4'h0, 0, 2, 0, 4'h0, 32'h0C7);
        add(0, 4'hA, 4'h0, 16'h0040, 12'h000, 32'h000, 4'h2, 0, 0, 0, 4'h0, 32'h000);
        add(0, 4'h8, 4'h0, 16'h0040, 12'h000, 32'h000, 4'h8, 4, 0, 0, 4'h0, 32'h000);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h0D0, 4'h0, 0, 0, 0, 4'h2, 32'h0D0);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h0D1, 4'h0, 0, 0, 0, 4'h8, 32'h0D1);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h000, 4'h0, 0, 0, 0, 4'h0, 32'h0D1);
        add(0, 4'h1, 4'h0, 16'h0000, 12'h000, 32'h000, 4'h1, 0, 0, 0, 4'h0, 32'h0D1);
        add(0, 4'h1, 4'h0, 16'h0004, 12'h000, 32'h000, 4'h1, 0, 0, 0, 4'h0, 32'h0D1);
        add(0, 4'h1, 4'h0, 16'h0000, 12'h000, 32'h0E0, 4'h1, 4, 0, 0, 4'h1, 32'h0E0);
        add(0, 4'h1, 4'h0, 16'h0004, 12'h000, 32'h0E1, 4'h1, 0, 0, 0, 4'h1, 32'h0E1);
        add(0, 4'h1, 4'h0, 16'h0000, 12'h000, 32'h0E2, 4'h1, 4, 0, 0, 4'h1, 32'h0E2);
        add(0, 4'h1, 4'h0, 16'h0004, 12'h000, 32'h0E3, 4'h1, 0, 0, 0, 4'h1, 32'h0E3);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h0E4, 4'h0, 4, 0, 0, 4'h1, 32'h0E4);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h0E5, 4'h0, 4, 0, 0, 4'h1, 32'h0E5);
        add(0, 4'h0, 4'h0, 16'h0000, 12'h000, 32'h000, 4'h0, 4, 0, 0, 4'h0, 32'h0E5);

        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst        = tbl[i].rst;
            req_valid  = tbl[i].v;
            req_we     = tbl[i].we;
            req_addr   = tbl[i].addr;
            req_wdata  = tbl[i].wd;
            cntr_rdata = tbl[i].rd;
            #1;
            chk("req_ready",  i, 32'(req_ready),  32'(tbl[i].rdy));
            chk("cntr_addr",  i, 32'(cntr_addr),  32'(tbl[i].caddr));
            chk("cntr_wdata", i, 32'(cntr_wdata), 32'(tbl[i].cwd));
            chk("cntr_w_en",  i, 32'(cntr_w_en),  32'(tbl[i].wen));
            chk("resp_valid", i, 32'(resp_valid), 32'(tbl[i].rv));
            chk("resp_rdata", i, resp_rdata,      tbl[i].rr);
        end

        // Single-core build: back-to-back reads from core 0.
        @(negedge clk);
        req_valid = '0; v1 = 1'b1; we1 = 1'b0; a1 = 4'd4; rd1 = '0;
        #1;
        chk("n1_ready", 100, 32'(rdy1), 32'd1);
        chk("n1_resp_valid", 100, 32'(rv1), 32'd0);
        @(negedge clk);
        a1 = 4'd0;
        #1;
        chk("n1_ready", 101, 32'(rdy1), 32'd1);
        chk("n1_cntr_addr", 101, 32'(ca1), 32'd4);
        @(negedge clk);
        v1 = 1'b0; rd1 = 32'h0F0;
        #1;
        chk("n1_ready", 102, 32'(rdy1), 32'd0);
        chk("n1_resp_valid", 102, 32'(rv1), 32'd1);
        chk("n1_resp_rdata", 102, rr1, 32'h0F0);
        chk("n1_cntr_addr", 102, 32'(ca1), 32'd0);
        @(negedge clk);
        rd1 = 32'h0F1;
        #1;
        chk("n1_resp_valid", 103, 32'(rv1), 32'd1);
        chk("n1_resp_rdata", 103, rr1, 32'h0F1);
        @(negedge clk);
        rd1 = 32'h0;
        #1;
        chk("n1_resp_valid", 104, 32'(rv1), 32'd0);
        chk("n1_resp_rdata", 104, rr1, 32'h0F1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_mmio_arbiter.md
Name: perf_mmio_arbiter

Overview:
Shares one performance-counter register port among NCORES cores in the multicore build. It sits directly upstream of the perf counter block. Each cycle it picks at most one core request by round-robin and drives the counter's address, write-data and write-enable. It then returns that counter's registered read data to the requesting core, two cycles after acceptance. Fully pipelined: one accepted request per cycle.

Parameters:
NCORES, 4, number of requesting cores (>=1); ID_W = max(1, clog2(NCORES)) is a derived localparam.

Ports:
clk_i  in  1  single clock
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  NCORES  per-core request valid
req_we_i  in  NCORES  per-core write flag (1=write, 0=read)
req_addr_i  in  4*NCORES  per-core register address, core k at [4k+3:4k]
req_wdata_i  in  3*NCORES  per-core write data, core k at [3k+2:3k]
req_ready_o  out  NCORES  per-core accept, one-hot or zero
resp_valid_o  out  NCORES  per-core response pulse, one-hot or zero
resp_rdata_o  out  32  response data shared by all cores
cntr_addr_o  out  4  to counter address input
cntr_wdata_o  out  3  to counter write-data input
cntr_w_en_o  out  1  to counter write enable
cntr_rdata_i  in  32  from counter, registered one cycle after address

Behaviour:
- Reset (rst_i high at a posedge) clears all state:
  - round-robin pointer = 0; both pipeline stage valids = 0.
  - cntr_addr_o = 0, cntr_wdata_o = 0, cntr_w_en_o = 0.
  - resp_valid_o = 0, resp_rdata_o = 0; req_ready_o = 0 while rst_i is high.
- Arbitration (combinational, cycle T):
  - Search req_valid_i starting at the pointer, ascending with wrap.
  - The first valid core k gets req_ready_o[k] = 1; all other ready bits are 0.
  - Acceptance = valid & ready in the same cycle.
  - A core must hold valid, we, addr and wdata stable until accepted.
  - No valid requests: ready = 0, pointer unchanged.
- Pointer update on acceptance by core k: pointer <= (k+1) mod NCORES.
- Stage 1, registered at T+1:
  - cntr_addr_o/cntr_wdata_o take core k's addr/wdata.
  - cntr_w_en_o = we of the accepted request; it is a 1-cycle pulse per accepted write.
  - s1 holds {valid=1, id=k, we}.
- Stage 1 with no acceptance at T: cntr_addr_o and cntr_wdata_o hold their last values; cntr_w_en_o = 0; s1 valid = 0.
- Stage 2, registered at T+2:
  - resp_valid_o[k] = 1 for exactly one cycle.
  - resp_rdata_o = cntr_rdata_i sampled at T+2 for reads; 0 for writes (write acknowledge).
  - When no response is due: resp_valid_o = 0 and resp_rdata_o holds its last value.
- Latency: acceptance at T gives a response at T+2. Back-to-back acceptances give back-to-back responses, in acceptance order.
- Addresses pass through unmodified; address decode is the counter's job:
  - 0 = control; write data [1:0] = 0 clear, 1 run, other values hold.
  - addr[2]=1 reads low word; addr[2]=0 reads high word.
- No response backpressure: cores must accept resp_valid_o whenever it is asserted.
- Reset mid-flight: in-flight requests are dropped with no response, and no write-enable pulse is issued after reset. Cores re-issue the request after reset.
- NCORES=1: core 0 is always the winner; pipeline behaviour is unchanged.

Decomposition:
- Package perf_pkg holds:
  - PERF_ADDR_CTRL=4'd0, PERF_ADDR_HI=4'd0, PERF_ADDR_LO=4'd4;
  - PERF_CTRL_CLEAR=2'd0, PERF_CTRL_RUN=2'd1, PERF_CTRL_HOLD=2'd2;
  - the address and write-data widths (4 and 3).
- One sub-module: perf_rr_arbiter (NCORES). Inputs: req vector and pointer. Outputs: one-hot grant, winning index, any-grant. Purely combinational.
- Pointer and pipeline registers stay in the top.

Test Plan:
- Single read: core0 reads addr 4 while the counter runs with cntr_rdata_i=32'h0000_0123 at T+2 -> req_ready_o[0]=1 at T; cntr_addr_o=4 at T+1; resp_valid_o=4'b0001 and resp_rdata_o=32'h123 at T+2.
- Write: core2 writes addr 0, data 3'b001 at T -> cntr_w_en_o=1, cntr_addr_o=0, cntr_wdata_o=1 at T+1 only; resp_valid_o=4'b0100 and resp_rdata_o=0 at T+2.
- All four cores request at the same time from pointer 0 -> grants 0,1,2,3 on consecutive cycles; responses 0001,0010,0100,1000 on cycles T+2..T+5.
- Fairness: cores 1 and 3 hold valid continuously for 8 cycles -> grants alternate 1,3,1,3...; neither waits more than 1 cycle.
- Reset mid-flight: accept a core1 write at T and assert rst_i at T+1 -> cntr_w_en_o=0 at T+1 and T+2; resp_valid_o stays 0; the next grant starts from core 0.
- Throughput: core0 issues 6 back-to-back reads alternating addr 0/4 -> 6 consecutive resp_valid_o pulses. Each resp_rdata_o equals cntr_rdata_i of its cycle, with no bubbles.
